// File: rtl/usb_tx_pkt.sv
// USB packet content serializer: PID byte, payload and CRC16, LSB first,
// handed to the low-level TX stage one bit per ll_ack.
module usb_tx_pkt (
    input  logic       clk,
    input  logic       rst,
    input  logic       pkt_start,
    output logic       pkt_done,
    input  logic [3:0] pkt_pid,
    input  logic [9:0] pkt_len,
    input  logic [7:0] pkt_data,
    output logic       pkt_data_ack,
    output logic       ll_start,
    output logic       ll_bit,
    output logic       ll_last,
    input  logic       ll_ack,
    input  logic       ll_done
);

    typedef enum logic [2:0] {S_IDLE, S_PID, S_DATA, S_CRC, S_WAIT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  pid_q, pid_nxt;
    logic [9:0]  byte_cnt, byte_cnt_nxt;
    logic [3:0]  bit_cnt, bit_cnt_nxt;
    logic [15:0] shift, shift_nxt;
    logic [15:0] crc, crc_nxt, crc_step;
    logic        ll_start_nxt, pkt_done_nxt;
    logic        is_data;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
    endfunction

    assign is_data  = (pid_q[1:0] == 2'b11);
    assign crc_step = crc16_step(crc, shift[0]);
    assign ll_bit   = (state == S_PID || state == S_DATA || state == S_CRC) ? shift[0] : 1'b0;
    assign ll_last  = (state == S_PID && bit_cnt == 4'd7 && !is_data) ||
                      (state == S_CRC && bit_cnt == 4'd15);

    always_comb begin
        state_nxt    = state;
        pid_nxt      = pid_q;
        byte_cnt_nxt = byte_cnt;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        crc_nxt      = crc;
        pkt_data_ack = 1'b0;
        ll_start_nxt = 1'b0;
        pkt_done_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                if (pkt_start) begin
                    pid_nxt      = pkt_pid;
                    byte_cnt_nxt = pkt_len;
                    shift_nxt    = {8'h00, ~pkt_pid, pkt_pid};
                    bit_cnt_nxt  = 4'd0;
                    crc_nxt      = 16'hFFFF;
                    ll_start_nxt = 1'b1;
                    state_nxt    = S_PID;
                end
            end
            S_PID: begin
                if (ll_ack) begin
                    shift_nxt   = shift >> 1;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_nxt = 4'd0;
                        if (!is_data) begin
                            state_nxt = S_WAIT;
                        end else if (byte_cnt == 10'd0) begin
                            shift_nxt = ~crc;
                            state_nxt = S_CRC;
                        end else begin
                            shift_nxt    = {8'h00, pkt_data};
                            pkt_data_ack = 1'b1;
                            byte_cnt_nxt = byte_cnt - 10'd1;
                            state_nxt    = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (ll_ack) begin
                    crc_nxt     = crc_step;
                    shift_nxt   = shift >> 1;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    // The CRC image must already include the byte's last bit.
                    if (bit_cnt == 4'd7) begin
                        bit_cnt_nxt = 4'd0;
                        if (byte_cnt != 10'd0) begin
                            shift_nxt    = {8'h00, pkt_data};
                            pkt_data_ack = 1'b1;
                            byte_cnt_nxt = byte_cnt - 10'd1;
                        end else begin
                            shift_nxt = ~crc_step;
                            state_nxt = S_CRC;
                        end
                    end
                end
            end
            S_CRC: begin
                if (ll_ack) begin
                    shift_nxt   = shift >> 1;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        bit_cnt_nxt = 4'd0;
                        state_nxt   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (ll_done) begin
                    pkt_done_nxt = 1'b1;
                    state_nxt    = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            byte_cnt <= 10'd0;
            bit_cnt  <= 4'd0;
            ll_start <= 1'b0;
            pkt_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
            bit_cnt  <= bit_cnt_nxt;
            ll_start <= ll_start_nxt;
            pkt_done <= pkt_done_nxt;
        end
    end

    // Datapath registers carry no reset; outputs derived from them are gated by state.
    always_ff @(posedge clk) begin
        pid_q <= pid_nxt;
        shift <= shift_nxt;
        crc   <= crc_nxt;
    end

endmodule

// File: tb/tb_usb_tx_pkt.sv
// Scoreboard bench for usb_tx_pkt: expected bit stream built per packet,
// popped and compared on every ll_ack.
module tb_usb_tx_pkt;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pkt_start = 1'b0;
    logic [3:0] pkt_pid = 4'd0;
    logic [9:0] pkt_len = 10'd0;
    logic [7:0] pkt_data = 8'd0;
    logic       ll_ack = 1'b0;
    logic       ll_done = 1'b0;
    logic       pkt_done, pkt_data_ack, ll_start, ll_bit, ll_last;

    int n_pass = 0;
    int n_total = 0;
    bit exp_bit_q[$];
    bit exp_last_q[$];
    logic [7:0] payload [0:1022];

    usb_tx_pkt dut (
        .clk(clk), .rst(rst),
        .pkt_start(pkt_start), .pkt_done(pkt_done),
        .pkt_pid(pkt_pid), .pkt_len(pkt_len),
        .pkt_data(pkt_data), .pkt_data_ack(pkt_data_ack),
        .ll_start(ll_start), .ll_bit(ll_bit), .ll_last(ll_last),
        .ll_ack(ll_ack), .ll_done(ll_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic build_expected(input logic [3:0] pid, input int len);
        logic [7:0]  pb;
        logic [15:0] crc;
        bit          b, fb;
        exp_bit_q.delete();
        exp_last_q.delete();
        pb = {~pid, pid};
        for (int i = 0; i < 8; i++) begin
            exp_bit_q.push_back(pb[i]);
            exp_last_q.push_back(1'b0);
        end
        if (pid[1:0] == 2'b11) begin
            crc = 16'hFFFF;
            for (int k = 0; k < len; k++) begin
                for (int i = 0; i < 8; i++) begin
                    b = payload[k][i];
                    exp_bit_q.push_back(b);
                    exp_last_q.push_back(1'b0);
                    fb  = crc[0] ^ b;
                    crc = {1'b0, crc[15:1]};
                    if (fb) crc = crc ^ 16'hA001;
                end
            end
            crc = ~crc;
            for (int i = 0; i < 16; i++) begin
                exp_bit_q.push_back(crc[i]);
                exp_last_q.push_back(1'b0);
            end
        end
        exp_last_q[exp_last_q.size() - 1] = 1'b1;
    endtask

    task automatic send_pkt(input string name, input logic [3:0] pid, input int len,
                            input int gmin, input int gmax, input bit busy_restart,
                            input int rst_at_bit);
        int acks = 0, dones = 0, extra_starts = 0, popped = 0, idle = 0;
        int gap = 1, data_idx = 0, cyc = 0;
        bit adv = 0, finished = 0, aborted = 0, r_data = 0;
        bit eb, el;
        build_expected(pid, len);
        @(negedge clk);
        pkt_pid   = pid;
        pkt_len   = len[9:0];
        pkt_data  = payload[0];
        pkt_start = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
        #1 check({name, ".ll_start"}, ll_start, 1);
        while (!finished) begin
            if (cyc > 0) @(negedge clk);
            if (adv) begin
                data_idx++;
                if (data_idx < len) pkt_data = payload[data_idx];
                adv = 0;
            end
            pkt_start = 1'b0;
            ll_done   = 1'b0;
            ll_ack    = 1'b0;
            if (rst_at_bit > 0 && popped == rst_at_bit) begin
                rst = 1'b1;
                #1 check({name, ".rst_outputs"},
                         {27'd0, ll_start, ll_bit, ll_last, pkt_data_ack, pkt_done}, 0);
                repeat (2) begin
                    @(negedge clk);
                    #1 check({name, ".rst_no_done"}, {30'd0, pkt_done, ll_bit}, 0);
                end
                rst = 1'b0;
                aborted  = 1;
                finished = 1;
            end else begin
                if (exp_bit_q.size() > 0) begin
                    if (gap <= 1) begin
                        ll_ack = 1'b1;
                        gap = $urandom_range(gmax, gmin);
                    end else begin
                        gap--;
                    end
                    if (busy_restart && popped == 12 && !r_data) begin
                        pkt_start = 1'b1;
                        pkt_pid   = 4'b0010;
                        pkt_len   = 10'd5;
                        r_data    = 1;
                    end
                end else begin
                    idle++;
                    if (busy_restart && idle == 1) begin
                        pkt_start = 1'b1;
                        pkt_pid   = 4'b0011;
                        pkt_len   = 10'd2;
                    end
                    if (idle == 3) ll_done = 1'b1;
                end
                #1;
                if (ll_ack) begin
                    eb = exp_bit_q.pop_front();
                    el = exp_last_q.pop_front();
                    check({name, ".bit"}, ll_bit, eb);
                    check({name, ".last"}, ll_last, el);
                    popped++;
                end
                if (pkt_data_ack) begin
                    acks++;
                    adv = 1;
                end
                if (ll_start && cyc > 0) extra_starts++;
                if (pkt_done) begin
                    dones++;
                    finished = 1;
                end
                cyc++;
                if (cyc > 60000) begin
                    check({name, ".timeout"}, 0, 1);
                    finished = 1;
                end
            end
        end
        ll_ack = 1'b0;
        ll_done = 1'b0;
        pkt_start = 1'b0;
        if (aborted) begin
            exp_bit_q.delete();
            exp_last_q.delete();
        end else begin
            check({name, ".bits_left"}, exp_bit_q.size(), 0);
            check({name, ".data_acks"}, acks, (pid[1:0] == 2'b11) ? len : 0);
            check({name, ".done_count"}, dones, 1);
            check({name, ".extra_ll_start"}, extra_starts, 0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1 check("reset.outputs", {27'd0, ll_start, ll_bit, ll_last, pkt_data_ack, pkt_done}, 0);
        rst = 1'b0;
        for (int k = 0; k < 1023; k++) payload[k] = 8'($urandom);

        send_pkt("ack", 4'b0010, 7, 4, 4, 0, 0);
        send_pkt("data1_len0", 4'b1011, 0, 1, 3, 0, 0);
        for (int k = 0; k < 4; k++) payload[k] = 8'(k);
        send_pkt("data0_len4", 4'b0011, 4, 1, 1, 0, 0);
        for (int k = 0; k < 1023; k++) payload[k] = 8'($urandom);
        send_pkt("restart_busy", 4'b1011, 6, 1, 2, 1, 0);
        send_pkt("after_done", 4'b1010, 0, 1, 2, 0, 0);
        send_pkt("rst_mid", 4'b0011, 5, 1, 2, 0, 8 + 16 + 3);
        send_pkt("after_rst", 4'b0011, 3, 1, 2, 0, 0);
        send_pkt("max_len", 4'b0111, 1023, 1, 6, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
